// File: rtl/axis_word_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : axis_word_serializer
//  Description : Fetches NUM_WORDS words from a synchronous read port and
//                streams them out byte by byte on an 8-bit AXI-Stream master,
//                with tlast on the frame's final byte and optional continuous
//                frame repetition.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_word_serializer #(
   parameter int ADDR_WIDTH  = 8,
   parameter int DATA_WIDTH  = 80,
   parameter int NUM_WORDS   = 4,
   parameter int ADDR_STRIDE = 4,
   parameter int BASE_ADDR   = 0,
   parameter int RD_LATENCY  = 1,
   parameter int MSB_FIRST   = 1
) (
   input  logic                  clk_in,
   input  logic                  rst_n_in,
   input  logic                  start_in,
   input  logic                  continuous_in,
   output logic                  busy_out,
   output logic                  frame_done_out,
   output logic                  rd_en,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [DATA_WIDTH-1:0] rd_data,
   output logic [7:0]            tdata_out,
   output logic                  tvalid_out,
   output logic                  tlast_out,
   input  logic                  tready_in
);

   localparam int c_BPW = DATA_WIDTH / 8;
   localparam int c_BW  = (c_BPW > 1) ? $clog2(c_BPW) : 1;
   localparam int c_WW  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

   localparam logic [c_BW-1:0]       c_LAST_BYTE = c_BW'(c_BPW - 1);
   localparam logic [c_WW-1:0]       c_LAST_WORD = c_WW'(NUM_WORDS - 1);
   localparam logic [1:0]            c_LAT_LAST  = 2'(RD_LATENCY - 1);
   localparam logic [ADDR_WIDTH-1:0] c_BASE      = ADDR_WIDTH'(BASE_ADDR);
   localparam logic [ADDR_WIDTH-1:0] c_STRIDE    = ADDR_WIDTH'(ADDR_STRIDE);
   localparam logic                  c_ONE_BYTE  = (c_BPW == 1);

   localparam logic [1:0] c_ST_IDLE  = 2'd0;
   localparam logic [1:0] c_ST_FETCH = 2'd1;
   localparam logic [1:0] c_ST_WAIT  = 2'd2;
   localparam logic [1:0] c_ST_SEND  = 2'd3;

   // Reject unsupported parameter combinations at elaboration time.
   generate
      if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8) begin : g_bad_data_width
         $error("axis_word_serializer: DATA_WIDTH must be a positive multiple of 8");
      end
      if (NUM_WORDS < 1) begin : g_bad_num_words
         $error("axis_word_serializer: NUM_WORDS must be at least 1");
      end
      if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
         $error("axis_word_serializer: RD_LATENCY must be within 1..4");
      end
   endgenerate

   logic [1:0]            r_state;
   logic                  r_busy;
   logic                  r_frame_done;
   logic                  r_rd_en;
   logic [ADDR_WIDTH-1:0] r_rd_addr;
   logic [DATA_WIDTH-1:0] r_shift;
   logic [7:0]            r_tdata;
   logic                  r_tvalid;
   logic                  r_tlast;
   logic [c_BW-1:0]       r_byte_idx;
   logic [c_WW-1:0]       r_word_idx;
   logic [1:0]            r_lat_cnt;

   // Byte presented at capture time and at each advance, plus the bytes
   // still to be sent; r_shift always holds the not-yet-presented bytes
   // aligned so the next one sits at the extraction end.
   logic [7:0]            w_cap_byte;
   logic [7:0]            w_adv_byte;
   logic [DATA_WIDTH-1:0] w_cap_rest;
   logic [DATA_WIDTH-1:0] w_adv_rest;
   logic                  w_last_byte;
   logic                  w_last_word;

   generate
      if (MSB_FIRST != 0) begin : g_msb_first
         assign w_cap_byte = rd_data[DATA_WIDTH-1 -: 8];
         assign w_cap_rest = rd_data << 8;
         assign w_adv_byte = r_shift[DATA_WIDTH-1 -: 8];
         assign w_adv_rest = r_shift << 8;
      end else begin : g_lsb_first
         assign w_cap_byte = rd_data[7:0];
         assign w_cap_rest = rd_data >> 8;
         assign w_adv_byte = r_shift[7:0];
         assign w_adv_rest = r_shift >> 8;
      end
   endgenerate

   assign w_last_byte = (r_byte_idx == c_LAST_BYTE);
   assign w_last_word = (r_word_idx == c_LAST_WORD);

   // Frame sequencer: issue reads, wait out the memory latency, then stream
   // the captured word byte by byte under tready back-pressure.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_state      <= c_ST_IDLE;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
         r_rd_en      <= 1'b0;
         r_rd_addr    <= c_BASE;
         r_shift      <= '0;
         r_tdata      <= 8'd0;
         r_tvalid     <= 1'b0;
         r_tlast      <= 1'b0;
         r_byte_idx   <= '0;
         r_word_idx   <= '0;
         r_lat_cnt    <= 2'd0;
      end else begin
         r_rd_en      <= 1'b0;
         r_frame_done <= 1'b0;
         case (r_state)
            c_ST_IDLE: begin
               if (start_in) begin
                  r_state    <= c_ST_FETCH;
                  r_busy     <= 1'b1;
                  r_rd_en    <= 1'b1;
                  r_rd_addr  <= c_BASE;
                  r_word_idx <= '0;
               end
            end
            c_ST_FETCH: begin
               r_state   <= c_ST_WAIT;
               r_lat_cnt <= 2'd0;
            end
            c_ST_WAIT: begin
               if (r_lat_cnt == c_LAT_LAST) begin
                  r_tdata    <= w_cap_byte;
                  r_shift    <= w_cap_rest;
                  r_byte_idx <= '0;
                  r_tvalid   <= 1'b1;
                  r_tlast    <= w_last_word && c_ONE_BYTE;
                  r_state    <= c_ST_SEND;
               end else begin
                  r_lat_cnt <= r_lat_cnt + 2'd1;
               end
            end
            c_ST_SEND: begin
               if (tready_in) begin
                  if (!w_last_byte) begin
                     // Next byte goes out at the same edge as the handshake.
                     r_tdata    <= w_adv_byte;
                     r_shift    <= w_adv_rest;
                     r_byte_idx <= r_byte_idx + 1'b1;
                     r_tlast    <= w_last_word && (r_byte_idx == (c_LAST_BYTE - 1'b1));
                  end else begin
                     r_tvalid   <= 1'b0;
                     r_tlast    <= 1'b0;
                     r_byte_idx <= '0;
                     if (!w_last_word) begin
                        r_word_idx <= r_word_idx + 1'b1;
                        r_rd_en    <= 1'b1;
                        r_rd_addr  <= r_rd_addr + c_STRIDE;
                        r_state    <= c_ST_FETCH;
                     end else begin
                        // End of frame: a pending start is deliberately
                        // ignored here, only continuous_in restarts.
                        r_frame_done <= 1'b1;
                        r_word_idx   <= '0;
                        if (continuous_in) begin
                           r_rd_en   <= 1'b1;
                           r_rd_addr <= c_BASE;
                           r_state   <= c_ST_FETCH;
                        end else begin
                           r_busy  <= 1'b0;
                           r_state <= c_ST_IDLE;
                        end
                     end
                  end
               end
            end
            default: begin
               r_state <= c_ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign busy_out       = r_busy;
   assign frame_done_out = r_frame_done;
   assign rd_en          = r_rd_en;
   assign rd_addr        = r_rd_addr;
   assign tdata_out      = r_tdata;
   assign tvalid_out     = r_tvalid;
   assign tlast_out      = r_tlast;

endmodule
`default_nettype wire

// File: doc/axis_word_serializer.md
Name: axis_word_serializer

Overview:
- Parametrised memory-to-stream serializer. Fetches NUM_WORDS words of DATA_WIDTH bits from a synchronous read port at BASE_ADDR + i*ADDR_STRIDE and emits them byte by byte on an 8-bit AXI-Stream master.
- Honours tready, marks the frame's final byte with tlast, and supports single-shot or continuous frame mode.
- Sits between the register/frame buffer and the byte-stream transmit path.

Parameters:
- ADDR_WIDTH, 8, read address width.
- DATA_WIDTH, 80, memory word width; must be a multiple of 8, >= 8.
- NUM_WORDS, 4, words per frame; >= 1.
- ADDR_STRIDE, 4, address increment between words.
- BASE_ADDR, 0, address of word 0.
- RD_LATENCY, 1, memory read latency in cycles from rd_en/rd_addr sampled to rd_data valid; range 1..4.
- MSB_FIRST, 1, 1: first byte = rd_data[DATA_WIDTH-1 -: 8]; 0: first byte = rd_data[7:0].

Ports:
- clk_in  input  1  Single clock; all logic is on posedge clk_in.
- rst_n_in  input  1  Reset: asynchronous, active-low.
- start_in  input  1  Frame request; sampled only in IDLE.
- continuous_in  input  1  1 = restart the frame automatically after tlast; sampled at the final handshake.
- busy_out  output  1  High whenever the FSM is not in IDLE.
- frame_done_out  output  1  One-cycle pulse after the tlast handshake.
- rd_en  output  1  One-cycle read strobe.
- rd_addr  output  ADDR_WIDTH  Read address; valid while rd_en = 1.
- rd_data  input  DATA_WIDTH  Read data, valid RD_LATENCY cycles after the strobe.
- tdata_out  output  8  Stream byte.
- tvalid_out  output  1  Stream valid.
- tlast_out  output  1  High on the last byte of the frame.
- tready_in  input  1  Stream ready from the sink.

Behaviour:
- Reset values: busy_out = 0, frame_done_out = 0, rd_en = 0, rd_addr = BASE_ADDR, tdata_out = 0, tvalid_out = 0, tlast_out = 0. Word index, byte index and latency counter clear to 0.
- Reset mid-frame aborts at once: no tlast is emitted, and the FSM returns to IDLE.
- All outputs are registered.
- IDLE: start_in = 1 at an edge -> FETCH. rd_en goes high for exactly one cycle with rd_addr = BASE_ADDR + word_idx*ADDR_STRIDE, truncated mod 2^ADDR_WIDTH (wrap-around is permitted).
- FETCH -> WAIT. Latency counter counts RD_LATENCY cycles.
- rd_data is captured into a DATA_WIDTH shift/hold register at the (RD_LATENCY+1)-th edge after the edge that raised rd_en. tvalid_out rises at the same edge -> SEND.
- Latency, RD_LATENCY = 1: start sampled at edge 0; rd_en high edge 0–1; data captured and tvalid high from edge 2.
- SEND: tdata_out = current byte in the order set by MSB_FIRST.
- AXI rule: while tvalid_out = 1 and tready_in = 0, tdata_out and tlast_out hold stable. tvalid never drops without a handshake.
- Each tvalid & tready edge advances the byte index. The next byte is presented at that same edge (back-to-back bytes when tready is held high).
- tlast_out = 1 only on byte DATA_WIDTH/8-1 of word NUM_WORDS-1.
- Handshake on the last byte of a non-final word: tvalid_out drops, word_idx++ -> FETCH. Inter-word gap = RD_LATENCY+1 cycles with tvalid low.
- Handshake with tlast:
  - frame_done_out pulses for 1 cycle and word_idx resets to 0.
  - If continuous_in = 1 -> FETCH (new frame, no idle cycle).
  - Otherwise -> IDLE, busy_out falls at that same edge.
- start_in while busy is ignored (not queued).
- start_in and the final handshake in the same cycle: start is ignored; only continuous_in decides a restart.
- NUM_WORDS = 1 and DATA_WIDTH = 8: every byte carries tlast. Each frame is a single FETCH/WAIT/SEND.
- Elaboration fails if DATA_WIDTH % 8 != 0, NUM_WORDS < 1, or RD_LATENCY is outside 1..4.

Test Plan:
- Defaults, memory model with latency 1 holding words 0x00/0x04/0x08/0x0C = 0x00112233445566778899, 0x0A..., 0x14..., 0x1E...; start pulse, tready = 1 -> rd_en at addresses 0,4,8,C. 40 bytes emitted, first bytes 0x00,0x11,…,0x99; 2-cycle gap between words. tlast only on byte 40; frame_done 1 cycle later; busy falls.
- Same frame with tready toggling pseudo-randomly (50%) -> identical byte sequence. tdata/tlast never change while tvalid = 1 and tready = 0.
- continuous_in = 1, 3 frames -> 120 bytes, 3 tlast pulses, 3 frame_done pulses, rd_addr cycling 0,4,8,C,0,…. Then drop continuous_in -> IDLE after the third tlast.
- MSB_FIRST = 0, RD_LATENCY = 3, word 0x0102030405060708090A -> bytes 0x0A,0x09,…,0x01; first tvalid 4 edges after rd_en rises.
- BASE_ADDR = 0xF8, ADDR_STRIDE = 4, NUM_WORDS = 4 -> rd_addr 0xF8,0xFC,0x00,0x04 (wrap).
- Assert rst_n_in low after byte 15 of a frame -> all outputs go to reset values asynchronously, no tlast. A fresh start then restarts at BASE_ADDR, byte 0.
